// File: rtl/message_receive_dp_pkg.sv
// Shared types and line-level constants for the serial message receiver.
package message_receive_dp_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/message_receive_dp_rx_bit_timer.sv
// Bit-period counter: free-runs from zero, wraps after BIT_PERIOD cycles,
// and flags the mid-bit and end-of-bit counts.
module message_receive_dp_rx_bit_timer #(
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned BIT_PERIOD = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);

    localparam logic [CNT_W-1:0] HalfCnt = CNT_W'(BIT_PERIOD / 2 - 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(BIT_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign half_tick = (cnt_q == HalfCnt);
    assign full_tick = (cnt_q == FullCnt);

    // Wrapping on full_tick keeps cnt within one bit period in every state.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || full_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/message_receive_dp.sv
// Serial-to-parallel receiver: synchronises the serial line, validates the
// start bit at mid-bit, shifts in LSB-first data and checks the stop bit.
module message_receive_dp
    import message_receive_dp_pkg::*;
#(
    parameter int unsigned DATA_W     = 5,
    parameter int unsigned BIT_PERIOD = 1024,
    parameter int unsigned CNT_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              ser_in,
    output logic [DATA_W-1:0] msg,
    output logic              msg_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DATA_W - 1);

    logic [1:0]        sync_q;
    logic              s;
    rx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] msg_q;
    logic              msg_valid_q, frame_err_q;
    logic              timer_clr, half_tick, full_tick;
    logic              sample, good_stop, bad_stop;

    // ser_in is asynchronous to clk; everything downstream looks only at s.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {2{LINE_IDLE}};
        end else begin
            sync_q <= {sync_q[0], ser_in};
        end
    end

    assign s = sync_q[1];

    message_receive_dp_rx_bit_timer #(
        .CNT_W      (CNT_W),
        .BIT_PERIOD (BIT_PERIOD)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (timer_clr),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_comb begin
        state_d   = state_q;
        timer_clr = 1'b0;
        sample    = 1'b0;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        if (!en) begin
            state_d   = StIdle;
            timer_clr = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    timer_clr = 1'b1;
                    if (s == START_LVL) begin
                        state_d = StStart;
                    end
                end
                StStart: begin
                    if (half_tick) begin
                        // Restart the timer here so later samples land mid-bit.
                        timer_clr = 1'b1;
                        state_d   = (s == START_LVL) ? StData : StIdle;
                    end
                end
                StData: begin
                    if (full_tick) begin
                        sample = 1'b1;
                        if (idx_q == LastIdx) begin
                            state_d = StStop;
                        end
                    end
                end
                StStop: begin
                    if (full_tick) begin
                        good_stop = (s == LINE_IDLE);
                        bad_stop  = (s != LINE_IDLE);
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            shreg_q     <= '0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_valid_q <= good_stop;
            frame_err_q <= bad_stop;
            if (!en || state_q == StIdle) begin
                idx_q <= '0;
            end else if (sample) begin
                idx_q <= idx_q + 1'b1;
            end
            if (sample) begin
                shreg_q <= {s, shreg_q[DATA_W-1:1]};
            end
            if (good_stop) begin
                msg_q <= shreg_q;
            end
        end
    end

    assign msg       = msg_q;
    assign msg_valid = msg_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_message_receive_dp.sv
// Directed bench for message_receive_dp at BIT_PERIOD=16, DATA_W=5.
module tb_message_receive_dp;

    localparam int unsigned DW = 5;
    localparam int unsigned BP = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          ser_in = 1'b1;
    logic [DW-1:0] msg;
    logic          msg_valid, frame_err, busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int vcnt   = 0;
    int ecnt   = 0;
    int t0     = 0;
    int vlog_msg [16];
    int vlog_cyc [16];

    message_receive_dp #(
        .DATA_W     (DW),
        .BIT_PERIOD (BP),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .ser_in    (ser_in),
        .msg       (msg),
        .msg_valid (msg_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every high cycle is counted, so a stretched pulse shows as an extra count.
    always @(negedge clk) begin
        if (msg_valid) begin
            vlog_msg[vcnt[3:0]] <= int'(msg);
            vlog_cyc[vcnt[3:0]] <= cyc;
            vcnt <= vcnt + 1;
        end
        if (frame_err) ecnt <= ecnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge after the stop bit ends.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop);
        ser_in = 1'b0;
        t0 = cyc;
        wait_cyc(BP);
        for (int i = 0; i < DW; i++) begin
            ser_in = d[i];
            wait_cyc(BP);
        end
        ser_in = stop;
        wait_cyc(BP);
    endtask

    initial begin
        // Reset state
        wait_cyc(3);
        check("rst_msg", int'(msg), 0);
        check("rst_valid", int'(msg_valid), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b1;
        en = 1'b1;
        wait_cyc(4);
        check("idle_busy", int'(busy), 0);

        // Good frame 10110 with latency 106 +/- 1
        send_frame(5'b10110, 1'b1);
        wait_cyc(4);
        check("good_vcnt", vcnt, 1);
        check("good_msg", vlog_msg[0], 'b10110);
        check("good_lat_in_window",
              int'((vlog_cyc[0] - t0 >= 105) && (vlog_cyc[0] - t0 <= 107)), 1);
        check("good_ecnt", ecnt, 0);
        check("good_hold", int'(msg), 'b10110);

        // Glitch: 3 low cycles, START entered then abandoned at mid-bit
        ser_in = 1'b0;
        wait_cyc(3);
        ser_in = 1'b1;
        wait_cyc(2);
        check("glitch_busy", int'(busy), 1);
        wait_cyc(9);
        check("glitch_idle", int'(busy), 0);
        wait_cyc(10);
        check("glitch_vcnt", vcnt, 1);
        check("glitch_ecnt", ecnt, 0);
        check("glitch_msg", int'(msg), 'b10110);

        // Bad stop bit
        send_frame(5'b00011, 1'b0);
        ser_in = 1'b1;
        wait_cyc(40);
        check("bad_ecnt", ecnt, 1);
        check("bad_vcnt", vcnt, 1);
        check("bad_msg", int'(msg), 'b10110);
        check("bad_idle", int'(busy), 0);

        // Back-to-back frames
        send_frame(5'b11111, 1'b1);
        send_frame(5'b00001, 1'b1);
        wait_cyc(4);
        check("b2b_vcnt", vcnt, 3);
        check("b2b_msg0", vlog_msg[1], 'b11111);
        check("b2b_msg1", vlog_msg[2], 'b00001);
        check("b2b_gap", vlog_cyc[2] - vlog_cyc[1], 7 * BP);
        check("b2b_ecnt", ecnt, 1);

        // en dropped during data bit 3 of 10101
        ser_in = 1'b0;
        wait_cyc(BP);
        ser_in = 1'b1;
        wait_cyc(BP);
        ser_in = 1'b0;
        wait_cyc(BP);
        ser_in = 1'b1;
        wait_cyc(BP);
        ser_in = 1'b0;
        wait_cyc(BP / 2);
        check("en_busy_before", int'(busy), 1);
        en = 1'b0;
        wait_cyc(1);
        check("en_busy_after", int'(busy), 0);
        ser_in = 1'b1;
        wait_cyc(5);
        en = 1'b1;
        wait_cyc(40);
        check("en_vcnt", vcnt, 3);
        check("en_ecnt", ecnt, 1);
        send_frame(5'b01010, 1'b1);
        wait_cyc(4);
        check("en_next_vcnt", vcnt, 4);
        check("en_next_msg", int'(msg), 'b01010);

        // Asynchronous reset while in STOP
        ser_in = 1'b0;
        wait_cyc(BP);
        for (int i = 0; i < 5; i++) begin
            ser_in = (i == 0 || i == 3 || i == 4) ? 1'b1 : 1'b0;
            wait_cyc(BP);
        end
        ser_in = 1'b1;
        wait_cyc(BP / 2);
        check("rstmid_busy_before", int'(busy), 1);
        #1 reset = 1'b0;
        #1;
        check("rstmid_msg", int'(msg), 0);
        check("rstmid_valid", int'(msg_valid), 0);
        check("rstmid_busy", int'(busy), 0);
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(30);
        check("rstmid_vcnt", vcnt, 4);
        check("rstmid_ecnt", ecnt, 1);
        send_frame(5'b00111, 1'b1);
        wait_cyc(4);
        check("rstmid_next_vcnt", vcnt, 5);
        check("rstmid_next_msg", int'(msg), 'b00111);
        check("final_ecnt", ecnt, 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/message_receive_dp.md
Name: message_receive_dp

Overview:
- Serial-to-parallel receiver sitting directly downstream of the message-processing serializer.
- Samples the single-bit serial line at a fixed bit period and reassembles each DATA_W-bit message from a start/data/stop frame.
- Presents each message on a parallel bus with a one-cycle valid strobe, and flags malformed frames.

Parameters:
- DATA_W, 5: message width in bits; data bits arrive LSB first.
- BIT_PERIOD, 1024: clock cycles per serial bit; must be even and >= 4.
- CNT_W, 10: bit-period counter width; must satisfy 2^CNT_W >= BIT_PERIOD.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- en  in  1  receive enable; 0 forces IDLE, and counters hold at zero.
- ser_in  in  1  serial line from the upstream serializer; asynchronous to clk, idle level 1.
- msg  out  DATA_W  last correctly received message; holds until the next good frame.
- msg_valid  out  1  one-cycle pulse when msg is updated.
- frame_err  out  1  one-cycle pulse when a frame's stop bit is sampled as 0.
- busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, msg=0, msg_valid=0, frame_err=0, busy=0.
  - Bit counter, bit index and shift register cleared.
  - Synchronizer flops set to 1 (idle line level).
- Input synchronizer: ser_in passes through 2 flops; s denotes the second-flop output, and all decisions use s.
- Frame on the line: start bit 0, then DATA_W data bits LSB first, then stop bit 1; each bit lasts BIT_PERIOD cycles.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - cnt=0, idx=0.
  - If en=1 and s=0, go to START with cnt=0.
- START:
  - cnt increments each cycle.
  - When cnt==BIT_PERIOD/2-1: if s=0, go to DATA with cnt=0 (mid-bit aligned); otherwise it was a glitch, so return to IDLE with no output.
- DATA:
  - cnt increments each cycle.
  - When cnt==BIT_PERIOD-1: shreg <= {s, shreg[DATA_W-1:1]}, idx++, cnt=0.
  - After the DATA_W-th sample, go to STOP.
- STOP:
  - When cnt==BIT_PERIOD-1:
    - s=1: msg<=shreg, msg_valid=1 for exactly one cycle.
    - s=0: frame_err=1 for exactly one cycle; msg unchanged.
  - In both cases go to IDLE.
- msg_valid and frame_err are registered and mutually exclusive, and both are 0 in every other cycle.
- Latency: msg_valid rises 2 + BIT_PERIOD/2 + (DATA_W+1)*BIT_PERIOD cycles after the start edge on ser_in, give or take 1 cycle of synchronizer phase.
- en=0 mid-frame: return to IDLE on the next edge. The partial frame is discarded, with no msg_valid and no frame_err.
- Back-to-back frames: IDLE re-arms in the cycle after STOP, so a start bit immediately following a stop bit is received.
- Line held at 0 after a frame_err: a new START is entered and then validated normally.
- Counter wrap: cnt never exceeds BIT_PERIOD-1; idx never exceeds DATA_W.
- Asynchronous reset mid-frame: all outputs drop to their reset values at once. After release, reception resumes only on the next s=0 seen in IDLE.

Decomposition:
- Shared package holds:
  - FSM state localparams: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Line-level constants: LINE_IDLE=1, START_LVL=0.
- One natural sub-module, rx_bit_timer:
  - Parameterised CNT_W/BIT_PERIOD counter with async active-low reset.
  - Synchronous clear input.
  - Outputs half_tick (cnt==BIT_PERIOD/2-1) and full_tick (cnt==BIT_PERIOD-1).

Test Plan:
- Good frame: BIT_PERIOD=16, DATA_W=5, en=1, send 5'b10110 -> one msg_valid pulse with msg=5'b10110 at the computed latency ±1; frame_err stays 0.
- Glitch rejection: ser_in low for 3 cycles then high -> back in IDLE after 2+8 cycles; no msg_valid, no frame_err, msg unchanged.
- Bad stop bit: send 5'b00011 with stop bit 0 -> frame_err pulses once; msg keeps its prior value 5'b10110.
- Back-to-back: 5'b11111 then 5'b00001 with no idle gap -> two msg_valid pulses 7*16 cycles apart, msg=5'b11111 then 5'b00001.
- en drop: en=0 during data bit 3 -> busy falls next cycle, no outputs; a following full frame 5'b01010 is received correctly.
- Reset mid-frame: assert reset=0 during STOP -> msg=0, msg_valid=0, busy=0 immediately; the next frame 5'b00111 is received normally.
